// File: rtl/ahb_wait_slave_if.sv
// AHB-Lite bus bundle between one master/mux side and the wait-state responder.
// HREADY is the bus-wide ready returned by the mux and is driven from the master side.
interface ahb_wait_slave_if #(
  parameter int Width = 32
);
  logic             HSELx;
  logic [Width-1:0] HADDR;
  logic             HWRITE;
  logic [2:0]       HSIZE;
  logic [2:0]       HBURST;
  logic [1:0]       HTRANS;
  logic             HREADY;
  logic [Width-1:0] HWDATA;
  logic             HREADYOUT;
  logic             HRESP;
  logic [Width-1:0] HRDATA;

  modport master (
    output HSELx, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HREADY, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSELx, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HREADY, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_wait_slave.sv
// AHB-Lite responder with a word-addressed register file, programmable wait states
// and the two-cycle ERROR response for misaligned, oversized or out-of-range transfers.
module ahb_wait_slave #(
  parameter int Width       = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 1,
  parameter int OFFSET_BITS = 12
) (
  input logic             HCLK,
  input logic             HRESETn,
  ahb_wait_slave_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DONE = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  localparam int IDX_W = OFFSET_BITS - 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]       r_state;
  logic [2:0]       w_nstate;
  logic [3:0]       r_cnt;
  logic [3:0]       w_ncnt;
  logic [AW-1:0]    r_idx;
  logic [1:0]       r_lane;
  logic [2:0]       r_size;
  logic             r_write;
  logic [Width-1:0] r_mem [DEPTH];

  logic             w_open;
  logic             w_accept;
  logic             w_size_ok;
  logic             w_range_ok;
  logic             w_legal;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_be;
  logic             w_unused;

  assign w_idx      = bus.HADDR[OFFSET_BITS-1:2];
  assign w_range_ok = (32'(w_idx) < 32'(DEPTH));
  assign w_legal    = w_size_ok & w_range_ok;
  assign w_unused   = ^{bus.HBURST, bus.HADDR[Width-1:OFFSET_BITS]};

  // Only states that drive HREADYOUT high can see a new address phase.
  assign w_open   = (r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR2);
  assign w_accept = w_open & bus.HSELx & bus.HREADY & bus.HTRANS[1];

  always_comb begin
    case (bus.HSIZE)
      3'd0:    w_size_ok = 1'b1;
      3'd1:    w_size_ok = ~bus.HADDR[0];
      3'd2:    w_size_ok = (bus.HADDR[1:0] == 2'b00);
      default: w_size_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    case (r_state)
      S_WAIT: begin
        w_ncnt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_nstate = S_DONE;
      end
      S_ERR1: w_nstate = S_ERR2;
      default: begin
        if (w_accept) begin
          if (!w_legal) begin
            w_nstate = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            w_nstate = S_DONE;
          end else begin
            w_nstate = S_WAIT;
            w_ncnt   = 4'(WAIT_STATES);
          end
        end else begin
          w_nstate = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
    end
  end

  // Address-phase capture; only consumed in DONE, so it carries no reset.
  always_ff @(posedge HCLK) begin
    if (w_accept) begin
      r_idx   <= AW'(w_idx);
      r_lane  <= bus.HADDR[1:0];
      r_size  <= bus.HSIZE;
      r_write <= bus.HWRITE;
    end
  end

  always_comb begin
    case (r_size)
      3'd0:    w_be = 4'b0001 << r_lane;
      3'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Write data arrives in the data phase, so the commit happens on the edge closing DONE.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if ((r_state == S_DONE) && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[r_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  assign bus.HREADYOUT = (r_state != S_WAIT) && (r_state != S_ERR1);
  assign bus.HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign bus.HRDATA    = ((r_state == S_DONE) && !r_write) ? r_mem[r_idx] : '0;
endmodule

// File: tb/tb_ahb_wait_slave.sv
// Directed bench for ahb_wait_slave: one instance with one wait state, one with none,
// each driven by a pipelined AHB master model and checked against a queued reference.
`timescale 1ns/1ps
module tb_ahb_wait_slave;
  typedef struct packed {
    logic [31:0] cycles;
    logic        resp;
    logic [31:0] rdata;
    logic [31:0] wdata;
  } exp_t;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  logic        sel   [2];
  logic [31:0] addr  [2];
  logic        wr    [2];
  logic [2:0]  size  [2];
  logic [2:0]  burst [2];
  logic [1:0]  trans [2];
  logic [31:0] wdat  [2];
  logic        rdy   [2];
  logic        resp  [2];
  logic [31:0] rdat  [2];

  ahb_wait_slave_if #(.Width(32)) ifc0 ();
  ahb_wait_slave_if #(.Width(32)) ifc1 ();

  assign ifc0.HSELx  = sel[0];   assign ifc1.HSELx  = sel[1];
  assign ifc0.HADDR  = addr[0];  assign ifc1.HADDR  = addr[1];
  assign ifc0.HWRITE = wr[0];    assign ifc1.HWRITE = wr[1];
  assign ifc0.HSIZE  = size[0];  assign ifc1.HSIZE  = size[1];
  assign ifc0.HBURST = burst[0]; assign ifc1.HBURST = burst[1];
  assign ifc0.HTRANS = trans[0]; assign ifc1.HTRANS = trans[1];
  assign ifc0.HWDATA = wdat[0];  assign ifc1.HWDATA = wdat[1];
  assign ifc0.HREADY = ifc0.HREADYOUT;
  assign ifc1.HREADY = ifc1.HREADYOUT;
  assign rdy[0]  = ifc0.HREADYOUT; assign rdy[1]  = ifc1.HREADYOUT;
  assign resp[0] = ifc0.HRESP;     assign resp[1] = ifc1.HRESP;
  assign rdat[0] = ifc0.HRDATA;    assign rdat[1] = ifc1.HRDATA;

  ahb_wait_slave #(.Width(32), .DEPTH(16), .WAIT_STATES(1), .OFFSET_BITS(12)) u0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(ifc0.slave));
  ahb_wait_slave #(.Width(32), .DEPTH(16), .WAIT_STATES(0), .OFFSET_BITS(12)) u1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(ifc1.slave));

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mdl [2][16];
  logic        infl [2];
  int          dcnt [2];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t front(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  task automatic pop(input int d);
    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask

  function automatic logic legal(input logic [2:0] sz, input logic [31:0] a);
    if (sz > 3'd2) return 1'b0;
    if (sz == 3'd1 && a[0]) return 1'b0;
    if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b0;
    return (a[11:2] < 10'd16);
  endfunction

  // One bus cycle: score the data phase at the falling edge, then cross the rising edge.
  task automatic cyc(input int d);
    exp_t e;
    logic acc;
    @(negedge HCLK);
    if (infl[d]) begin
      e = front(d);
      dcnt[d]++;
      if (rdy[d]) begin
        chk($sformatf("dut%0d beats", d), 32'(dcnt[d]), e.cycles);
        chk($sformatf("dut%0d resp", d), 32'(resp[d]), 32'(e.resp));
        chk($sformatf("dut%0d rdata", d), rdat[d], e.rdata);
        pop(d);
        infl[d] = 1'b0;
      end else begin
        chk($sformatf("dut%0d stall_resp", d), 32'(resp[d]), 32'(e.resp));
      end
    end
    acc = sel[d] & rdy[d] & trans[d][1];
    @(posedge HCLK);
    #1;
    if (acc) begin
      e = front(d);
      wdat[d]  = e.wdata;
      infl[d]  = 1'b1;
      dcnt[d]  = 0;
      sel[d]   = 1'b0;
      trans[d] = 2'b00;
    end
  endtask

  task automatic xfer(input int d, input logic [1:0] tr, input logic w, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    logic ok;
    int   idx;
    int   guard;
    ok       = legal(sz, a);
    idx      = int'(a[11:2]);
    e.cycles = ok ? ((d == 0) ? 32'd2 : 32'd1) : 32'd2;
    e.resp   = ~ok;
    e.wdata  = w ? wd : 32'h0;
    e.rdata  = 32'h0;
    if (ok && w) begin
      for (int b = 0; b < 4; b++) begin
        logic hit;
        hit = (sz == 3'd0) ? (b == int'(a[1:0])) : (sz == 3'd1) ? ((b >> 1) == int'(a[1])) : 1'b1;
        if (hit) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
      end
    end else if (ok) begin
      e.rdata = mdl[d][idx];
    end
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    sel[d] = 1'b1; trans[d] = tr; wr[d] = w; size[d] = sz; addr[d] = a;
    guard = 0;
    while (sel[d] && guard < 40) begin
      cyc(d);
      guard++;
    end
    if (sel[d]) begin
      total++; bad++;
      $error("FAIL dut%0d accept_timeout: observed=pending expected=accepted", d);
      sel[d] = 1'b0; trans[d] = 2'b00;
    end
  endtask

  task automatic drain(input int d);
    int guard;
    guard = 0;
    while (infl[d] && guard < 40) begin
      cyc(d);
      guard++;
    end
    if (infl[d]) begin
      total++; bad++;
      $error("FAIL dut%0d drain_timeout: observed=busy expected=idle", d);
      infl[d] = 1'b0;
    end
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      infl[d] = 1'b0;
      dcnt[d] = 0;
      for (int i = 0; i < 16; i++) mdl[d][i] = 32'h0;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      sel[d] = 1'b0; addr[d] = 32'h0; wr[d] = 1'b0; size[d] = 3'd0;
      burst[d] = 3'd0; trans[d] = 2'b00; wdat[d] = 32'h0;
    end
    clear_model();
    HRESETn = 1'b1;
    #1 HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d reset_ready", d), 32'(rdy[d]), 32'h1);
      chk($sformatf("dut%0d reset_resp", d), 32'(resp[d]), 32'h0);
      chk($sformatf("dut%0d reset_rdata", d), rdat[d], 32'h0);
    end
    @(posedge HCLK);
    #1 HRESETn = 1'b1;

    // Word write then read back, one wait state each.
    xfer(0, 2'b10, 1'b1, 3'd2, 32'h08, 32'hDEADBEEF);
    xfer(0, 2'b10, 1'b0, 3'd2, 32'h08, 32'h0);
    // Byte and halfword merges into the same word.
    xfer(0, 2'b10, 1'b1, 3'd0, 32'h09, 32'h0000AA00);
    xfer(0, 2'b10, 1'b1, 3'd1, 32'h0A, 32'h12340000);
    xfer(0, 2'b10, 1'b0, 3'd2, 32'h08, 32'h0);
    // Out-of-range index, then confirm storage untouched.
    xfer(0, 2'b10, 1'b0, 3'd2, 32'h40, 32'h0);
    xfer(0, 2'b10, 1'b1, 3'd2, 32'h44, 32'hFFFFFFFF);
    xfer(0, 2'b10, 1'b0, 3'd2, 32'h08, 32'h0);
    // Misaligned half and illegal size, then an OKAY accepted during ERR2.
    xfer(0, 2'b10, 1'b0, 3'd1, 32'h03, 32'h0);
    xfer(0, 2'b10, 1'b1, 3'd3, 32'h00, 32'h11111111);
    xfer(0, 2'b10, 1'b1, 3'd2, 32'h04, 32'h00C0FFEE);
    xfer(0, 2'b10, 1'b0, 3'd2, 32'h04, 32'h0);
    xfer(0, 2'b10, 1'b0, 3'd2, 32'h00, 32'h0);
    drain(0);

    // Transfer not addressed to this slave: no data phase at all.
    trans[0] = 2'b10; addr[0] = 32'h08; wr[0] = 1'b1;
    repeat (2) begin
      @(negedge HCLK);
      chk("dut0 unsel_ready", 32'(rdy[0]), 32'h1);
      chk("dut0 unsel_resp", 32'(resp[0]), 32'h0);
      @(posedge HCLK);
      #1;
    end
    trans[0] = 2'b00;
    xfer(0, 2'b10, 1'b0, 3'd2, 32'h08, 32'h0);
    drain(0);

    // Zero-wait INCR burst of writes then reads.
    burst[1] = 3'b001;
    xfer(1, 2'b10, 1'b1, 3'd2, 32'h00, 32'hA0A0A0A0);
    xfer(1, 2'b11, 1'b1, 3'd2, 32'h04, 32'hB1B1B1B1);
    xfer(1, 2'b11, 1'b1, 3'd2, 32'h08, 32'hC2C2C2C2);
    xfer(1, 2'b11, 1'b1, 3'd2, 32'h0C, 32'hD3D3D3D3);
    xfer(1, 2'b10, 1'b0, 3'd2, 32'h00, 32'h0);
    xfer(1, 2'b11, 1'b0, 3'd2, 32'h04, 32'h0);
    xfer(1, 2'b11, 1'b0, 3'd2, 32'h08, 32'h0);
    xfer(1, 2'b11, 1'b0, 3'd2, 32'h0C, 32'h0);
    drain(1);
    burst[1] = 3'b000;
    xfer(1, 2'b10, 1'b0, 3'd2, 32'h3C, 32'h0);
    xfer(1, 2'b10, 1'b0, 3'd2, 32'h40, 32'h0);
    drain(1);

    // Reset during the wait state of a write aborts it.
    xfer(0, 2'b10, 1'b1, 3'd2, 32'h10, 32'hCAFEF00D);
    @(negedge HCLK);
    chk("dut0 pre_reset_ready", 32'(rdy[0]), 32'h0);
    #2 HRESETn = 1'b0;
    #1;
    chk("dut0 async_reset_ready", 32'(rdy[0]), 32'h1);
    chk("dut0 async_reset_resp", 32'(resp[0]), 32'h0);
    chk("dut0 async_reset_rdata", rdat[0], 32'h0);
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    clear_model();
    xfer(0, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
    xfer(0, 2'b10, 1'b0, 3'd2, 32'h08, 32'h0);
    drain(0);
    xfer(1, 2'b10, 1'b0, 3'd2, 32'h04, 32'h0);
    drain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb_wait_slave.md
Name: ahb_wait_slave

Overview:
- AHB-Lite responder (slave end of the master/decoder/mux bus) with a word-addressed register-file memory.
- Inserts a parameterised number of wait states per transfer.
- Returns the two-cycle ERROR response for illegal transfers.
- Connects to a decoder HSEL line and drives the mux HRDATA/HRESP/HREADYOUT inputs; drop-in peer for the existing slaves on the bus.

Parameters:
- Width, 32, data and address bus width.
- DEPTH, 16, number of Width-bit words of storage.
- WAIT_STATES, 1, HREADYOUT-low cycles inserted per OKAY transfer (0..15).
- OFFSET_BITS, 12, low HADDR bits decoded locally; the decoder handles the upper bits.

Ports:
- HCLK  input  1  bus clock, rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- HSELx  input  1  slave select from the decoder.
- HADDR  input  Width  transfer address.
- HWRITE  input  1  1 = write, 0 = read.
- HSIZE  input  3  0 = byte, 1 = half, 2 = word; others illegal.
- HBURST  input  3  burst type; informational only, no behaviour depends on it.
- HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HREADY  input  1  bus-wide ready from the mux.
- HWDATA  input  Width  write data, valid in the data phase.
- HREADYOUT  output  1  this slave's ready.
- HRESP  output  1  0 = OKAY, 1 = ERROR.
- HRDATA  output  Width  read data.

Behaviour:
- Reset (async, HRESETn=0):
  - Outputs: HREADYOUT=1, HRESP=0, HRDATA=0.
  - FSM to IDLE; wait counter=0; all memory words=0.
  - Reset asserted mid-transfer aborts it; a pending write is not committed.
- Address-phase accept: HSELx & HREADY & HTRANS[1] on a rising edge. Latch HADDR, HWRITE, HSIZE.
- IDLE/BUSY, or HSELx=0 with HREADY=1: no data phase follows; slave stays IDLE with HREADYOUT=1, HRESP=0.
- Legality check at accept:
  - Illegal if HSIZE>2.
  - Illegal if HSIZE=1 and HADDR[0]=1.
  - Illegal if HSIZE=2 and HADDR[1:0]!=0.
  - Illegal if HADDR[OFFSET_BITS-1:2] >= DEPTH.
- FSM states IDLE, WAIT, DONE, ERR1, ERR2:
  - IDLE: on legal accept, go to WAIT and load counter=WAIT_STATES (WAIT_STATES=0 goes straight to DONE). On illegal accept, go to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle; in the cycle it is 1, next state is DONE. Inputs are ignored; no accept is possible because HREADY is low.
  - DONE: HREADYOUT=1, HRESP=0; this is the completion cycle.
    - Write: commit HWDATA at the rising edge ending DONE, into byte lanes selected by HSIZE/HADDR[1:0] (byte: lane HADDR[1:0]; half: lanes {HADDR[1],0}+0/1; word: all four). Other lanes are unchanged.
    - Read: HRDATA = full stored word at the latched index, valid throughout DONE.
    - A new accept in DONE (pipelined) goes to WAIT/DONE/ERR1 per its legality; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Always go to ERR2. No memory write.
  - ERR2: HREADYOUT=1, HRESP=1. A new accept here is honoured, as in DONE; otherwise go to IDLE.
  - Errors never insert WAIT_STATES.
- HRDATA outside a read DONE cycle: 0.
- Latency (OKAY): data phase = WAIT_STATES+1 cycles. Back-to-back NONSEQ/SEQ transfers are sustained with no idle gap between data phases.
- Read-after-write to the same word in consecutive transfers returns the newly written data.
- DEPTH need not be a power of two; out-of-range indices are caught by the legality check and never wrap.

Test Plan:
- Reset, then word write 0xDEADBEEF to offset 0x08 with WAIT_STATES=1, then read 0x08:
  - Each data phase shows HREADYOUT 0 then 1, HRESP=0.
  - Read returns 0xDEADBEEF.
- Byte write 0xAA to 0x09, then half write 0x1234 to 0x0A, then word read 0x08 -> HRDATA=0x1234AAEF.
- Word read at offset 0x40 with DEPTH=16 -> HREADYOUT/HRESP = 0/1 then 1/1, no wait states; memory unchanged.
- Half access at 0x03 and HSIZE=3 at 0x00 -> each gives a two-cycle ERROR; a NONSEQ accepted in the ERR2 cycle then completes OKAY.
- WAIT_STATES=0, four-beat INCR burst of writes to 0x00..0x0C, then burst read -> one cycle per beat, data returned in order, HREADYOUT stays 1.
- HRESETn pulsed low during WAIT of a write -> outputs at reset values immediately (async); a subsequent read of that word returns 0.
